// File: rtl/ifq.sv
// Instruction fetch queue: credit-limited sequential fetch into an in-order {pc, inst} FIFO
// that feeds decode, with redirect flush and drop-counting of stale in-flight responses.
module ifq #(
    parameter int                     DEPTH       = 4,
    parameter int                     IM_ADDR_LEN = 32,
    parameter int                     IM_DATA_LEN = 32,
    parameter logic [IM_ADDR_LEN-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   redirect,
    input  logic [IM_ADDR_LEN-1:0] redirect_pc,
    output logic                   imem_req,
    output logic [IM_ADDR_LEN-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [IM_DATA_LEN-1:0] imem_rdata,
    output logic [IM_DATA_LEN-1:0] inst,
    output logic                   inst_valid,
    output logic [IM_ADDR_LEN-1:0] pc,
    input  logic                   id_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]          FULL_CNT = DEPTH[CW-1:0];
    localparam logic [CW:0]            FULL_LVL = DEPTH[CW:0];
    localparam logic [IM_ADDR_LEN-1:0] STEP     = IM_ADDR_LEN'(4);

    logic [IM_ADDR_LEN-1:0] fetch_pc;
    logic [IM_ADDR_LEN-1:0] resp_pc;
    logic [IM_ADDR_LEN-1:0] redirect_base;
    logic [IM_ADDR_LEN-1:0] pc_mem   [DEPTH];
    logic [IM_DATA_LEN-1:0] inst_mem [DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          outst;
    logic [CW-1:0]          discard;
    logic [CW:0]            committed;
    logic                   credit;
    logic                   grant;
    logic                   push;
    logic                   drop;
    logic                   pop;
    logic                   redirect_pc_unused;

    assign redirect_base      = {redirect_pc[IM_ADDR_LEN-1:2], 2'b00};
    assign redirect_pc_unused = |redirect_pc[1:0];

    // Credit looks only at registered occupancy, so a same-cycle pop or response frees nothing yet.
    assign committed = {1'b0, count} + {1'b0, outst};
    assign credit    = committed < FULL_LVL;

    assign imem_req   = rstn & credit & ~redirect;
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req & imem_gnt;
    assign push       = imem_rvalid & ~redirect & (discard == '0);
    assign drop       = imem_rvalid & ~redirect & (discard != '0);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & id_ready & ~redirect;
    assign inst       = inst_mem[rd_ptr];
    assign pc         = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outst    <= '0;
            discard  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= RESET_PC;
                inst_mem[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // outst already includes responses still pending discard, so every survivor is stale.
            outst    <= outst - CW'(imem_rvalid);
            discard  <= outst - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + STEP;
            end
            outst <= outst + CW'(grant) - CW'(imem_rvalid);
            if (drop) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                pc_mem[wr_ptr]   <= resp_pc;
                inst_mem[wr_ptr] <= imem_rdata;
                wr_ptr           <= wr_ptr + PW'(1);
                resp_pc          <= resp_pc + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_rvalid_has_owner: assert property (@(posedge clk) disable iff (!rstn)
        imem_rvalid |-> (outst != '0));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
        (imem_rvalid && !redirect && discard == '0) |-> (count != FULL_CNT));

endmodule

// File: tb/tb_ifq.sv
// Bench for ifq: fixed vector table, directed corner sequences and a randomized run,
// all checked against a queue-based model of the fetch/flush behaviour.
module tb_ifq;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        id_ready = 1'b0;

    ifq #(.DEPTH(DEPTH), .IM_ADDR_LEN(32), .IM_DATA_LEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst),
        .inst_valid(inst_valid), .pc(pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // memory environment
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int last_due = 0;
    bit const_data = 1'b0;
    int n_gnt = 0;

    // reference model
    typedef struct { logic [31:0] addr; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    infl_t m_infl[$];
    ent_t  m_q[$];
    logic [31:0] m_fetch = RST_PC;

    // last sampled outputs and popped pcs
    bit          s_req;
    logic [31:0] s_addr;
    bit          s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_inst;
    logic [31:0] pops[$];

    typedef struct {
        bit rd; logic [31:0] rpc; bit rdy;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (const_data) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit rd, input logic [31:0] rpc, input bit rdy,
                              input bit rv, input bit g);
        infl_t r;
        if (rd) begin
            if (rv && m_infl.size() > 0) m_infl.delete(0);
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_q.delete();
            m_fetch = {rpc[31:2], 2'b00};
        end else begin
            if (m_q.size() > 0 && rdy) m_q.delete(0);
            if (rv && m_infl.size() > 0) begin
                r = m_infl[0];
                m_infl.delete(0);
                if (!r.stale) m_q.push_back('{r.addr, mdata(r.addr)});
            end
            if (g) begin
                m_infl.push_back('{m_fetch, 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit exp_req;
        bit rv;
        int lat;
        int due;
        @(negedge clk);
        rstn        = 1'b1;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        rv = 1'b0;
        imem_rdata = $urandom;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            imem_rdata = mdata(mq[0].addr);
            mq.delete(0);
        end
        imem_rvalid = rv;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_pc = pc; s_inst = inst;
        exp_req = (m_q.size() + m_infl.size() < DEPTH) && !rd;
        check("imem_req", s_req, exp_req);
        check("imem_addr", s_addr, m_fetch);
        check("inst_valid", s_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("head_pc", s_pc, m_q[0].pc);
            check("head_inst", s_inst, m_q[0].inst);
        end
        if (s_valid && rdy && !rd) pops.push_back(s_pc);
        if (s_req && imem_gnt) begin
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{s_addr, due});
            n_gnt++;
        end
        model_step(rd, rpc, rdy, rv, exp_req && imem_gnt);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_pc", pc, RST_PC);
        check("rst_inst", inst, 0);
        check("rst_addr", imem_addr, RST_PC);
        mq.delete(); m_q.delete(); m_infl.delete(); pops.delete();
        m_fetch = RST_PC; last_due = 0; n_gnt = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit reached;

        // zero-wait memory, constant nop data: startup, redirect, fill and resume
        tbl[0]  = '{0, 32'h0,    1, 1, 32'h1000, 0, 32'h0};
        tbl[1]  = '{0, 32'h0,    1, 1, 32'h1004, 0, 32'h0};
        tbl[2]  = '{0, 32'h0,    1, 1, 32'h1008, 1, 32'h1000};
        tbl[3]  = '{0, 32'h0,    1, 1, 32'h100C, 1, 32'h1004};
        tbl[4]  = '{1, 32'h2003, 1, 0, 32'h1010, 1, 32'h1008};
        tbl[5]  = '{0, 32'h0,    1, 1, 32'h2000, 0, 32'h0};
        tbl[6]  = '{0, 32'h0,    1, 1, 32'h2004, 0, 32'h0};
        tbl[7]  = '{0, 32'h0,    1, 1, 32'h2008, 1, 32'h2000};
        tbl[8]  = '{0, 32'h0,    0, 1, 32'h200C, 1, 32'h2004};
        tbl[9]  = '{0, 32'h0,    0, 1, 32'h2010, 1, 32'h2004};
        tbl[10] = '{0, 32'h0,    0, 0, 32'h2014, 1, 32'h2004};
        tbl[11] = '{0, 32'h0,    0, 0, 32'h2014, 1, 32'h2004};
        tbl[12] = '{0, 32'h0,    1, 0, 32'h2014, 1, 32'h2004};
        tbl[13] = '{0, 32'h0,    1, 1, 32'h2014, 1, 32'h2008};

        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; const_data = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
            check("tbl_req", s_req, tbl[i].e_req);
            check("tbl_addr", s_addr, tbl[i].e_addr);
            check("tbl_valid", s_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check("tbl_pc", s_pc, tbl[i].e_pc);
                check("tbl_inst", s_inst, 32'h0000_0013);
            end
        end
        const_data = 1'b0;

        // fill with decode stalled, then drain
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (8) cycle(0, 0, 0);
        check("fill_grants", n_gnt, 4);
        check("fill_req_off", s_req, 0);
        cycle(0, 0, 1);
        check("resume_hold", s_req, 0);
        cycle(0, 0, 1);
        check("resume_req", s_req, 1);
        repeat (6) cycle(0, 0, 1);
        check("drain_count", pops.size() >= 4, 1);
        for (int i = 0; i < 4 && i < pops.size(); i++)
            check("drain_pc", pops[i], RST_PC + 32'(4 * i));

        // slow memory, two outstanding, redirect drops both stale responses
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        gnt_pct = 0;
        cycle(1, 32'h2000, 1);
        gnt_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 1);
            if (s_valid) found = 1'b1;
        end
        check("redir_seen", found, 1);
        if (found) begin
            check("redir_pc", s_pc, 32'h2000);
            check("redir_inst", s_inst, mdata(32'h2000));
        end

        // redirect coinciding with a response while out of credit
        do_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (4) cycle(0, 0, 0);
        cycle(1, 32'h3000, 0);
        cycle(0, 0, 0);
        check("rr_valid", s_valid, 0);
        check("rr_req", s_req, 1);
        check("rr_addr", s_addr, 32'h3000);

        // full queue with simultaneous pop and push, pointer wrap
        do_reset();
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        repeat (6) cycle(0, 0, 0);
        repeat (20) cycle(0, 0, 1);
        check("wrap_pops", pops.size() >= 12, 1);
        check("wrap_first", pops.size() > 0 ? pops[0] : 32'hx, RST_PC);
        for (int i = 1; i < pops.size(); i++)
            check("wrap_order", pops[i], pops[i-1] + 32'd4);

        // reset mid-operation with entries queued and requests outstanding
        do_reset();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        reached = 1'b0;
        for (int i = 0; i < 12 && !reached; i++) begin
            cycle(0, 0, 0);
            if (m_q.size() >= 2 && m_infl.size() >= 2) reached = 1'b1;
        end
        check("midrst_setup", reached, 1);
        do_reset();
        cycle(0, 0, 1);
        check("midrst_req", s_req, 1);
        check("midrst_addr", s_addr, RST_PC);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) begin
                gnt_pct = $urandom_range(30, 100);
                lat_min = 1;
                lat_max = $urandom_range(1, 5);
            end
            cycle($urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
